// File: rtl/alu_result_serializer_pkg.sv
// Shared definitions for the ALU result serializer: FSM encoding, default
// result width and the byte-count constant/helper.
package alu_result_serializer_pkg;

    localparam int unsigned DEFAULT_OUT_WIDTH = 16;
    localparam int unsigned BYTE_COUNT        = DEFAULT_OUT_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    function automatic int unsigned byte_count(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/alu_result_serializer_if.sv
// Bundle of the result input, UART transmitter handshake and status flags.
interface alu_result_serializer_if
    import alu_result_serializer_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = DEFAULT_OUT_WIDTH
) ();

    logic [OUT_WIDTH-1:0] ALU_OUT;
    logic                 OUT_VALID;
    logic                 TX_BUSY;
    logic [7:0]           TX_DATA;
    logic                 TX_VALID;
    logic                 BUSY;
    logic                 DROP;

    modport slave (
        input  ALU_OUT, OUT_VALID, TX_BUSY,
        output TX_DATA, TX_VALID, BUSY, DROP
    );

    modport master (
        output ALU_OUT, OUT_VALID, TX_BUSY,
        input  TX_DATA, TX_VALID, BUSY, DROP
    );

endinterface

// File: rtl/alu_result_serializer.sv
// Splits ALU results into bytes for a UART transmitter, with one active
// result slot, a one-deep pending slot and a sticky overflow flag.
module alu_result_serializer
    import alu_result_serializer_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = DEFAULT_OUT_WIDTH,
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    alu_result_serializer_if.slave bus
);

    localparam int unsigned      N        = byte_count(OUT_WIDTH);
    localparam int unsigned      IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_e               state_q, state_d;
    logic [OUT_WIDTH-1:0] active_q, active_d;
    logic [OUT_WIDTH-1:0] pending_q, pending_d;
    logic                 pending_vld_q, pending_vld_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 busy_q, busy_d;
    logic                 drop_q, drop_d;
    logic                 promote_s;
    logic                 take_direct_s;

    // Byte k of the transmit sequence; MSB-first mode walks the word downwards.
    function automatic logic [7:0] pick_byte(input logic [OUT_WIDTH-1:0] word,
                                             input logic [IDX_W-1:0]     k);
        logic [IDX_W-1:0] pos;
        pos = (LSB_FIRST != 0) ? k : (LAST_IDX - k);
        return word[{pos, 3'b000} +: 8];
    endfunction

    // Next-state, slot management and registered-output computation.
    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        pending_d     = pending_q;
        pending_vld_d = pending_vld_q;
        idx_d         = idx_q;
        drop_d        = drop_q;
        tx_data_d     = tx_data_q;
        promote_s     = 1'b0;
        take_direct_s = (state_q == IDLE) && !pending_vld_q;

        case (state_q)
            IDLE: begin
                if (pending_vld_q) begin
                    active_d      = pending_q;
                    pending_vld_d = 1'b0;
                    idx_d         = '0;
                    promote_s     = 1'b1;
                    state_d       = SEND;
                end else if (bus.OUT_VALID) begin
                    active_d = bus.ALU_OUT;
                    idx_d    = '0;
                    state_d  = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (bus.TX_BUSY) begin
                    state_d = WAIT_ACK;
                end else begin
                    state_d = SEND;
                end
            end
            WAIT_ACK: begin
                if (!bus.TX_BUSY) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (idx_q != LAST_IDX) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = SEND;
                end else if (pending_vld_q) begin
                    active_d      = pending_q;
                    pending_vld_d = 1'b0;
                    idx_d         = '0;
                    promote_s     = 1'b1;
                    state_d       = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A result arriving while the pending slot is being vacated is kept.
        if (bus.OUT_VALID && !take_direct_s) begin
            if (!pending_vld_q || promote_s) begin
                pending_d     = bus.ALU_OUT;
                pending_vld_d = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end else begin
            drop_d = drop_q;
        end

        tx_valid_d = (state_d == SEND);
        if (state_d == SEND) begin
            tx_data_d = pick_byte(active_d, idx_d);
        end else begin
            tx_data_d = tx_data_q;
        end
        busy_d = (state_d != IDLE) || pending_vld_d;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= IDLE;
            active_q      <= '0;
            pending_q     <= '0;
            pending_vld_q <= 1'b0;
            idx_q         <= '0;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            pending_vld_q <= pending_vld_d;
            idx_q         <= idx_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            busy_q        <= busy_d;
            drop_q        <= drop_d;
        end
    end

    assign bus.TX_DATA  = tx_data_q;
    assign bus.TX_VALID = tx_valid_q;
    assign bus.BUSY     = busy_q;
    assign bus.DROP     = drop_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench: an LSB-first and an MSB-first instance, each served by a
// simple UART model that holds TX_BUSY for a programmable number of cycles.
module tb_alu_result_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    alu_result_serializer_if #(.OUT_WIDTH(16)) ifa ();
    alu_result_serializer_if #(.OUT_WIDTH(16)) ifb ();

    alu_result_serializer #(.OUT_WIDTH(16), .LSB_FIRST(1)) dut_lsb (
        .CLK (clk),
        .RST (rst),
        .bus (ifa.slave)
    );

    alu_result_serializer #(.OUT_WIDTH(16), .LSB_FIRST(0)) dut_msb (
        .CLK (clk),
        .RST (rst),
        .bus (ifb.slave)
    );

    always #5 clk = ~clk;

    int         pulse_len_a = 10;
    int         cnt_a = 0;
    int         cnt_b = 0;
    logic [7:0] log_a[$];
    logic [7:0] log_b[$];

    // Transmitter model for the LSB-first instance: accept, then stay busy.
    always @(negedge clk) begin
        if (rst) begin
            cnt_a = 0;
            ifa.TX_BUSY = 1'b0;
        end else if (cnt_a != 0) begin
            cnt_a = cnt_a - 1;
            ifa.TX_BUSY = (cnt_a != 0);
        end else if (ifa.TX_VALID === 1'b1) begin
            log_a.push_back(ifa.TX_DATA);
            cnt_a = pulse_len_a;
            ifa.TX_BUSY = 1'b1;
        end
    end

    // Transmitter model for the MSB-first instance.
    always @(negedge clk) begin
        if (rst) begin
            cnt_b = 0;
            ifb.TX_BUSY = 1'b0;
        end else if (cnt_b != 0) begin
            cnt_b = cnt_b - 1;
            ifb.TX_BUSY = (cnt_b != 0);
        end else if (ifb.TX_VALID === 1'b1) begin
            log_b.push_back(ifb.TX_DATA);
            cnt_b = 10;
            ifb.TX_BUSY = 1'b1;
        end
    end

    function automatic logic [7:0] byte_a(input int i);
        if (i < log_a.size()) return log_a[i];
        else return 8'hxx;
    endfunction

    function automatic logic [7:0] byte_b(input int i);
        if (i < log_b.size()) return log_b[i];
        else return 8'hxx;
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle_a(input string tag, input int budget);
        int n;
        n = 0;
        while (ifa.BUSY !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check1(tag, ifa.BUSY, 1'b0);
    endtask

    task automatic wait_idle_b(input string tag, input int budget);
        int n;
        n = 0;
        while (ifb.BUSY !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check1(tag, ifb.BUSY, 1'b0);
    endtask

    initial begin
        int base;
        ifa.ALU_OUT = 16'h0000; ifa.OUT_VALID = 1'b0;
        ifb.ALU_OUT = 16'h0000; ifb.OUT_VALID = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check8("rst_tx_data", ifa.TX_DATA, 8'h00);
        check1("rst_tx_valid", ifa.TX_VALID, 1'b0);
        check1("rst_busy", ifa.BUSY, 1'b0);
        check1("rst_drop", ifa.DROP, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check1("post_rst_busy", ifa.BUSY, 1'b0);

        // Single result, LSB first, with first-byte latency
        base = log_a.size();
        ifa.ALU_OUT = 16'hA55A; ifa.OUT_VALID = 1'b1;
        @(posedge clk); #1;
        ifa.OUT_VALID = 1'b0;
        check1("single_lat_valid", ifa.TX_VALID, 1'b1);
        check8("single_lat_data", ifa.TX_DATA, 8'h5A);
        check1("single_busy", ifa.BUSY, 1'b1);
        wait_idle_a("single_idle", 200);
        checkn("single_count", log_a.size() - base, 2);
        check8("single_b0", byte_a(base), 8'h5A);
        check8("single_b1", byte_a(base + 1), 8'hA5);
        check1("single_drop", ifa.DROP, 1'b0);

        // Back-to-back results on consecutive cycles
        base = log_a.size();
        ifa.ALU_OUT = 16'h0001; ifa.OUT_VALID = 1'b1;
        @(posedge clk); #1;
        ifa.ALU_OUT = 16'h0002;
        @(posedge clk); #1;
        ifa.OUT_VALID = 1'b0;
        check1("b2b_busy", ifa.BUSY, 1'b1);
        wait_idle_a("b2b_idle", 300);
        checkn("b2b_count", log_a.size() - base, 4);
        check8("b2b_b0", byte_a(base), 8'h01);
        check8("b2b_b1", byte_a(base + 1), 8'h00);
        check8("b2b_b2", byte_a(base + 2), 8'h02);
        check8("b2b_b3", byte_a(base + 3), 8'h00);
        check1("b2b_drop", ifa.DROP, 1'b0);

        // Long transmitter stall after the first byte is accepted
        pulse_len_a = 100;
        base = log_a.size();
        ifa.ALU_OUT = 16'hC3D4; ifa.OUT_VALID = 1'b1;
        @(posedge clk); #1;
        ifa.OUT_VALID = 1'b0;
        check1("stall_valid", ifa.TX_VALID, 1'b1);
        check8("stall_data", ifa.TX_DATA, 8'hD4);
        repeat (50) @(posedge clk);
        #1;
        check1("stall_mid_valid", ifa.TX_VALID, 1'b0);
        check8("stall_mid_data", ifa.TX_DATA, 8'hD4);
        checkn("stall_mid_count", log_a.size() - base, 1);
        wait_idle_a("stall_idle", 600);
        checkn("stall_count", log_a.size() - base, 2);
        check8("stall_b0", byte_a(base), 8'hD4);
        check8("stall_b1", byte_a(base + 1), 8'hC3);
        pulse_len_a = 10;

        // Overflow: third result arrives with the pending slot full
        base = log_a.size();
        ifa.ALU_OUT = 16'h0011; ifa.OUT_VALID = 1'b1;
        @(posedge clk); #1;
        ifa.ALU_OUT = 16'h0022;
        @(posedge clk); #1;
        check1("ovf_drop_after_2", ifa.DROP, 1'b0);
        ifa.ALU_OUT = 16'h0033;
        @(posedge clk); #1;
        ifa.OUT_VALID = 1'b0;
        check1("ovf_drop_after_3", ifa.DROP, 1'b1);
        wait_idle_a("ovf_idle", 300);
        checkn("ovf_count", log_a.size() - base, 4);
        check8("ovf_b0", byte_a(base), 8'h11);
        check8("ovf_b1", byte_a(base + 1), 8'h00);
        check8("ovf_b2", byte_a(base + 2), 8'h22);
        check8("ovf_b3", byte_a(base + 3), 8'h00);
        check1("ovf_drop_sticky", ifa.DROP, 1'b1);

        // Only reset clears DROP
        rst = 1'b1;
        @(posedge clk); #1;
        check1("drop_cleared", ifa.DROP, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Reset while waiting for the first byte's acknowledge, one pending
        base = log_a.size();
        ifa.ALU_OUT = 16'hBEEF; ifa.OUT_VALID = 1'b1;
        @(posedge clk); #1;
        check8("mid_first_data", ifa.TX_DATA, 8'hEF);
        ifa.ALU_OUT = 16'h1357;
        @(posedge clk); #1;
        ifa.OUT_VALID = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check1("mid_wait_ack_valid", ifa.TX_VALID, 1'b0);
        check1("mid_wait_ack_busy", ifa.BUSY, 1'b1);
        checkn("mid_first_count", log_a.size() - base, 1);
        #2 rst = 1'b1;
        #1;
        check8("mid_rst_data", ifa.TX_DATA, 8'h00);
        check1("mid_rst_valid", ifa.TX_VALID, 1'b0);
        check1("mid_rst_busy", ifa.BUSY, 1'b0);
        check1("mid_rst_drop", ifa.DROP, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        checkn("mid_after_count", log_a.size() - base, 1);
        check1("mid_after_busy", ifa.BUSY, 1'b0);
        check1("mid_after_valid", ifa.TX_VALID, 1'b0);

        // MSB-first instance
        base = log_b.size();
        ifb.ALU_OUT = 16'h1234; ifb.OUT_VALID = 1'b1;
        @(posedge clk); #1;
        ifb.OUT_VALID = 1'b0;
        check1("msb_lat_valid", ifb.TX_VALID, 1'b1);
        check8("msb_lat_data", ifb.TX_DATA, 8'h12);
        wait_idle_b("msb_idle", 200);
        checkn("msb_count", log_b.size() - base, 2);
        check8("msb_b0", byte_b(base), 8'h12);
        check8("msb_b1", byte_b(base + 1), 8'h34);
        check1("msb_drop", ifb.DROP, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_serializer.md
ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

Interface
REQ-001 Parameter OUT_WIDTH, default 16, SHALL set the ALU result width and must be a multiple of 8.
REQ-002 Parameter LSB_FIRST, default 1, SHALL select byte order: 1 = least-significant byte first, 0 = most-significant byte first.
REQ-003 Port CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port RST  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port ALU_OUT  input  OUT_WIDTH  SHALL carry the ALU result to be transmitted.
REQ-006 Port OUT_VALID  input  1  SHALL qualify ALU_OUT for one cycle per result.
REQ-007 Port TX_BUSY  input  1  SHALL indicate that the downstream UART transmitter is occupied.
REQ-008 Port TX_DATA  output  8  SHALL carry the byte offered to the transmitter.
REQ-009 Port TX_VALID  output  1  SHALL indicate that TX_DATA is offered.
REQ-010 Port BUSY  output  1  SHALL be high whenever any result is held or in transmission.
REQ-011 Port DROP  output  1  SHALL be a sticky flag set when a result is lost.

Function
REQ-012 The block SHALL hold two result slots: ACTIVE (being sent) and PENDING (queued, one deep).
REQ-013 FSM states SHALL be IDLE, SEND, WAIT_ACK, WAIT_DONE.
REQ-014 IDLE: on OUT_VALID=1, ALU_OUT SHALL be loaded into ACTIVE, byte index cleared, next state SEND.
REQ-015 SEND: TX_VALID=1 with TX_DATA = selected byte; on TX_BUSY=1, next state WAIT_ACK... TX_VALID SHALL drop the cycle after TX_BUSY is sampled high.
REQ-016 WAIT_ACK: hold until TX_BUSY=0, then next state WAIT_DONE for one cycle of byte-index update.
REQ-017 WAIT_DONE: if bytes remain, increment index and go to SEND; else if PENDING valid, move PENDING to ACTIVE, clear PENDING, go to SEND; else go to IDLE.
REQ-018 TX_DATA and TX_VALID SHALL be registered outputs; TX_DATA SHALL stay stable while TX_VALID=1.
REQ-019 Byte select: byte k = ACTIVE[8k+7:8k] with k running 0..N-1 when LSB_FIRST=1, N-1..0 otherwise, N = OUT_WIDTH/8.
REQ-020 OUT_VALID outside IDLE with PENDING empty SHALL load PENDING; with PENDING full the new result SHALL be discarded and DROP set.
REQ-021 OUT_VALID in the same cycle PENDING is moved to ACTIVE SHALL load PENDING (no drop).
REQ-022 OUT_VALID in IDLE SHALL never set DROP; DROP SHALL clear only on reset.
REQ-023 BUSY SHALL equal (state != IDLE) OR PENDING valid, registered.
REQ-024 Latency: first TX_VALID SHALL assert the cycle after OUT_VALID is sampled in IDLE.

Reset
REQ-025 RST=1 SHALL asynchronously force IDLE, TX_DATA=0, TX_VALID=0, BUSY=0, DROP=0, both slots invalid.
REQ-026 Reset mid-frame SHALL abandon the current and pending results without further TX_VALID.
REQ-027 Exit from reset SHALL occur on the first CLK edge with RST=0; no result sampled earlier.

Structure
REQ-028 FSM state encoding and the byte-count constant SHALL live in the shared system package.
REQ-029 The design SHALL be a single module; a sub-module is not required.
REQ-030 No combinational path SHALL exist from TX_BUSY or OUT_VALID to any output.

Verification
REQ-031 Single result: ALU_OUT=16'hA55A, OUT_VALID one cycle, TX_BUSY pulses 10 cycles per accept -> bytes 8'h5A then 8'hA5, BUSY falls after second ack, DROP=0.
REQ-032 LSB_FIRST=0: ALU_OUT=16'h1234 -> bytes 8'h12 then 8'h34.
REQ-033 Back-to-back: results 16'h0001, 16'h0002 on consecutive cycles -> bytes 01,00,02,00 in order, DROP=0.
REQ-034 Overflow: three results 16'h0011, 16'h0022, 16'h0033 within the first byte -> bytes 11,00,22,00 only, DROP=1 after third.
REQ-035 Reset in WAIT_ACK of first byte of 16'hBEEF with one pending -> outputs zero immediately, no further TX_VALID, BUSY=0.
REQ-036 Stall: TX_BUSY held high 100 cycles during SEND -> TX_DATA stable, TX_VALID drops after acceptance, no byte duplicated.
